// File: rtl/trigger_pulse_seq.sv
// trigger_pulse_seq: sequences the trigger output pulse train on trigger_clk.
// On an enabled match event it snapshots the pulse count, the per-pulse delays
// and the per-pulse widths, then plays up to pNUM_TRIGGER_PULSES pulses.
//
// Ports:
//   trigger_clk      trigger clock
//   reset_i          asynchronous active-high reset
//   I_enable         sequencer enable (synchronous to trigger_clk)
//   I_match          single-cycle match event
//   I_num_triggers   pulses per sequence (clamped to pNUM_TRIGGER_PULSES)
//   I_trigger_delay  packed delays, pulse k at [k*pDELAY_WIDTH +: pDELAY_WIDTH]
//   I_trigger_width  packed widths, pulse k at [k*pWIDTH_WIDTH +: pWIDTH_WIDTH]
//   O_trigger        registered trigger output
//   O_busy           sequence in progress (DELAY or PULSE)
//   O_pulse_index    index of current/next pulse
//   O_done           one-cycle pulse on normal completion
//   O_missed_count   ignored-match counter (only with TRIGGER_SEQ_MISSED_CNT_EN)
//
// Optional feature macro: TRIGGER_SEQ_MISSED_CNT_EN
module trigger_pulse_seq #(
  parameter int unsigned pNUM_TRIGGER_PULSES = 8,
  parameter int unsigned pNUM_TRIGGER_WIDTH  = 4,
  parameter int unsigned pDELAY_WIDTH        = 24,
  parameter int unsigned pWIDTH_WIDTH        = 24
) (
  input  logic                                          trigger_clk,
  input  logic                                          reset_i,
  input  logic                                          I_enable,
  input  logic                                          I_match,
  input  logic [pNUM_TRIGGER_WIDTH-1:0]                 I_num_triggers,
  input  logic [pNUM_TRIGGER_PULSES*pDELAY_WIDTH-1:0]   I_trigger_delay,
  input  logic [pNUM_TRIGGER_PULSES*pWIDTH_WIDTH-1:0]   I_trigger_width,
  output logic                                          O_trigger,
  output logic                                          O_busy,
  output logic [pNUM_TRIGGER_WIDTH-1:0]                 O_pulse_index,
  output logic                                          O_done
`ifdef TRIGGER_SEQ_MISSED_CNT_EN
  ,
  output logic [7:0]                                    O_missed_count
`endif
);

  localparam int unsigned NP = pNUM_TRIGGER_PULSES;
  localparam int unsigned NW = pNUM_TRIGGER_WIDTH;
  localparam int unsigned DW = pDELAY_WIDTH;
  localparam int unsigned WW = pWIDTH_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_PULSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [NW-1:0]    idx_q, idx_d;
  logic [NW-1:0]    count_q, count_d;
  logic [DW-1:0]    dcnt_q, dcnt_d;
  logic [WW-1:0]    wcnt_q, wcnt_d;
  logic [NP*DW-1:0] dsnap_q, dsnap_d;
  logic [NP*WW-1:0] wsnap_q, wsnap_d;
  logic             trig_d;
  logic             busy_d;

  logic [NW-1:0]    num_eff_c;
  logic [WW-1:0]    wid_cur_c;
  logic [DW-1:0]    dly_nxt_c;

  // Requested pulse count clamped to the number of programmable slots
  assign num_eff_c = (32'(I_num_triggers) > NP) ? NW'(NP) : I_num_triggers;

  // Width of the current pulse and delay of the following pulse from the snapshot
  always_comb begin
    wid_cur_c = '0;
    dly_nxt_c = '0;
    for (int unsigned k = 0; k < NP; k++) begin
      if (32'(idx_q) == k)
        wid_cur_c = wsnap_q[k*WW +: WW];
      if (32'(idx_q) + 32'd1 == k)
        dly_nxt_c = dsnap_q[k*DW +: DW];
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    count_d = count_q;
    dcnt_d  = dcnt_q;
    wcnt_d  = wcnt_q;
    dsnap_d = dsnap_q;
    wsnap_d = wsnap_q;
    trig_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (I_match && I_enable) begin
          if (num_eff_c != '0) begin
            count_d = num_eff_c;
            dsnap_d = I_trigger_delay;
            wsnap_d = I_trigger_width;
            dcnt_d  = I_trigger_delay[DW-1:0];
            idx_d   = '0;
            state_d = ST_DELAY;
          end else begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DELAY: begin
        if (!I_enable) begin
          idx_d   = '0;
          state_d = ST_IDLE;
        end else if (dcnt_q == '0) begin
          trig_d  = 1'b1;
          // A zero width still produces a one-cycle pulse
          wcnt_d  = (wid_cur_c == '0) ? WW'(1) : wid_cur_c;
          state_d = ST_PULSE;
        end else begin
          dcnt_d = dcnt_q - DW'(1);
        end
      end

      ST_PULSE: begin
        if (!I_enable) begin
          idx_d   = '0;
          state_d = ST_IDLE;
        end else if (wcnt_q == WW'(1)) begin
          if (32'(idx_q) + 32'd1 < 32'(count_q)) begin
            idx_d   = idx_q + NW'(1);
            // The falling edge itself supplies one low cycle of the gap
            dcnt_d  = (dly_nxt_c == '0) ? '0 : dly_nxt_c - DW'(1);
            state_d = ST_DELAY;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          trig_d = 1'b1;
          wcnt_d = wcnt_q - WW'(1);
        end
      end

      ST_DONE: begin
        idx_d   = '0;
        state_d = ST_IDLE;
      end

      default: begin
        idx_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_DELAY) || (state_d == ST_PULSE);
  end

  // State, counters, snapshots and registered outputs
  always_ff @(posedge trigger_clk or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      count_q       <= '0;
      dcnt_q        <= '0;
      wcnt_q        <= '0;
      dsnap_q       <= '0;
      wsnap_q       <= '0;
      O_trigger     <= 1'b0;
      O_busy        <= 1'b0;
      O_pulse_index <= '0;
      O_done        <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      count_q       <= count_d;
      dcnt_q        <= dcnt_d;
      wcnt_q        <= wcnt_d;
      dsnap_q       <= dsnap_d;
      wsnap_q       <= wsnap_d;
      O_trigger     <= trig_d;
      O_busy        <= busy_d;
      O_pulse_index <= idx_d;
      O_done        <= (state_q == ST_DONE);
    end
  end

`ifdef TRIGGER_SEQ_MISSED_CNT_EN
  logic       en_q;
  logic [7:0] missed_q;

  // Saturating count of enabled matches that arrive outside IDLE
  always_ff @(posedge trigger_clk or posedge reset_i) begin
    if (reset_i) begin
      en_q     <= 1'b0;
      missed_q <= '0;
    end else begin
      en_q <= I_enable;
      if (I_enable && !en_q)
        missed_q <= '0;
      else if (I_enable && I_match && (state_q != ST_IDLE) && (missed_q != 8'hFF))
        missed_q <= missed_q + 8'd1;
    end
  end

  assign O_missed_count = missed_q;
`endif

endmodule

// File: tb/tb_trigger_pulse_seq.sv
// Directed bench for trigger_pulse_seq. Delay field is narrowed to 12 bits so
// the maximum-delay case (rise 2^DW cycles after the match) stays short.
module tb_trigger_pulse_seq;

  localparam int unsigned NP = 8;
  localparam int unsigned NW = 4;
  localparam int unsigned DW = 12;
  localparam int unsigned WW = 8;

  logic               trigger_clk;
  logic               reset_i;
  logic               I_enable;
  logic               I_match;
  logic [NW-1:0]      I_num_triggers;
  logic [NP*DW-1:0]   I_trigger_delay;
  logic [NP*WW-1:0]   I_trigger_width;
  logic               O_trigger;
  logic               O_busy;
  logic [NW-1:0]      O_pulse_index;
  logic               O_done;
`ifdef TRIGGER_SEQ_MISSED_CNT_EN
  logic [7:0]         O_missed_count;
`endif

  trigger_pulse_seq #(
    .pNUM_TRIGGER_PULSES(NP),
    .pNUM_TRIGGER_WIDTH (NW),
    .pDELAY_WIDTH       (DW),
    .pWIDTH_WIDTH       (WW)
  ) dut (
    .trigger_clk    (trigger_clk),
    .reset_i        (reset_i),
    .I_enable       (I_enable),
    .I_match        (I_match),
    .I_num_triggers (I_num_triggers),
    .I_trigger_delay(I_trigger_delay),
    .I_trigger_width(I_trigger_width),
    .O_trigger      (O_trigger),
    .O_busy         (O_busy),
    .O_pulse_index  (O_pulse_index),
    .O_done         (O_done)
`ifdef TRIGGER_SEQ_MISSED_CNT_EN
    ,
    .O_missed_count (O_missed_count)
`endif
  );

  initial trigger_clk = 1'b0;
  always #5 trigger_clk = ~trigger_clk;

  int          pass_cnt = 0;
  int          total    = 0;
  int          n;
  logic [63:0] tr_trig, tr_busy, tr_done;
  logic [NW-1:0] tr_idx [64];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge trigger_clk);
    #1;
  endtask

  task automatic cfg(input int num);
    I_num_triggers  = NW'(num);
    I_trigger_delay = '0;
    I_trigger_width = '0;
  endtask

  task automatic set_pulse(input int k, input int d, input int w);
    I_trigger_delay[k*DW +: DW] = DW'(d);
    I_trigger_width[k*WW +: WW] = WW'(w);
  endtask

  // Match sampled on the next edge t; returns 1 time unit after edge t
  task automatic do_match();
    I_match = 1'b1;
    tick();
    I_match = 1'b0;
  endtask

  // Bit i of each trace = output after edge t+i; optional extra match / enable drop
  task automatic run_trace(input int cycles, input int match_at, input int dis_at);
    tr_trig = '0;
    tr_busy = '0;
    tr_done = '0;
    for (int i = 0; i < cycles; i++) begin
      tr_trig[i] = O_trigger;
      tr_busy[i] = O_busy;
      tr_done[i] = O_done;
      tr_idx[i]  = O_pulse_index;
      I_match = (i == match_at);
      if (i == dis_at) I_enable = 1'b0;
      tick();
    end
    I_match = 1'b0;
  endtask

  initial begin
    reset_i  = 1'b1;
    I_enable = 1'b0;
    I_match  = 1'b0;
    cfg(0);
    repeat (3) tick();
    chk("reset_trigger", 64'(O_trigger), 64'd0);
    chk("reset_busy", 64'(O_busy), 64'd0);
    chk("reset_index", 64'(O_pulse_index), 64'd0);
    chk("reset_done", 64'(O_done), 64'd0);
    reset_i = 1'b0;
    tick();

    // Match while disabled starts nothing
    cfg(1); set_pulse(0, 1, 1);
    do_match();
    run_trace(8, -1, -1);
    chk("disabled_trig", tr_trig, 64'h0);
    chk("disabled_busy", tr_busy, 64'h0);
    I_enable = 1'b1;
    tick();

    // Single pulse: delay 5, width 3
    cfg(1); set_pulse(0, 5, 3);
    do_match();
    run_trace(16, -1, -1);
    chk("single_trig", tr_trig, 64'h1C0);
    chk("single_busy", tr_busy, 64'h1FF);
    chk("single_done", tr_done, 64'h400);

    // Three pulses: delays {0,2,4}, widths {1,2,3}
    cfg(3); set_pulse(0, 0, 1); set_pulse(1, 2, 2); set_pulse(2, 4, 3);
    do_match();
    run_trace(20, -1, -1);
    chk("three_trig", tr_trig, 64'h1C32);
    chk("three_busy", tr_busy, 64'h1FFF);
    chk("three_done", tr_done, 64'h4000);
    chk("three_idx1", 64'(tr_idx[1]), 64'd0);
    chk("three_idx3", 64'(tr_idx[3]), 64'd1);
    chk("three_idx8", 64'(tr_idx[8]), 64'd2);
    chk("three_idx15", 64'(tr_idx[15]), 64'd0);

    // Zero count: done only
    cfg(0); set_pulse(0, 1, 1);
    do_match();
    run_trace(8, -1, -1);
    chk("zero_trig", tr_trig, 64'h0);
    chk("zero_busy", tr_busy, 64'h0);
    chk("zero_done", tr_done, 64'h2);

    // Count 15 clamps to 8 pulses
    cfg(15);
    for (int k = 0; k < int'(NP); k++) set_pulse(k, 0, 1);
    do_match();
    run_trace(24, -1, -1);
    chk("clamp_trig", tr_trig, 64'hAAAA);
    chk("clamp_busy", tr_busy, 64'hFFFF);
    chk("clamp_done", tr_done, 64'h20000);

    // Second match during DELAY is ignored
    cfg(2); set_pulse(0, 3, 2); set_pulse(1, 3, 2);
    do_match();
    run_trace(16, 1, -1);
    chk("rematch_trig", tr_trig, 64'h630);
    chk("rematch_busy", tr_busy, 64'h7FF);
    chk("rematch_done", tr_done, 64'h1000);
`ifdef TRIGGER_SEQ_MISSED_CNT_EN
    chk("missed_one", 64'(O_missed_count), 64'd1);
    cfg(1); set_pulse(0, 400, 1);
    do_match();
    I_match = 1'b1;
    repeat (300) tick();
    I_match = 1'b0;
    chk("missed_sat", 64'(O_missed_count), 64'd255);
    I_enable = 1'b0;
    tick(); tick();
    I_enable = 1'b1;
    tick();
    chk("missed_clear", 64'(O_missed_count), 64'd0);
`endif

    // Enable dropped during PULSE aborts without done
    cfg(2); set_pulse(0, 1, 5); set_pulse(1, 1, 1);
    do_match();
    run_trace(16, -1, 3);
    chk("abort_trig", tr_trig, 64'hC);
    chk("abort_busy", tr_busy, 64'hF);
    chk("abort_done", tr_done, 64'h0);
    I_enable = 1'b1;
    tick();
    do_match();
    run_trace(16, -1, -1);
    chk("restart_trig", tr_trig, 64'h17C);
    chk("restart_done", tr_done, 64'h400);
    chk("restart_idx0", 64'(tr_idx[0]), 64'd0);
    chk("restart_idx8", 64'(tr_idx[8]), 64'd1);

    // Asynchronous reset mid-PULSE
    cfg(1); set_pulse(0, 0, 10);
    do_match();
    tick(); tick();
    chk("prereset_trig", 64'(O_trigger), 64'd1);
    #3 reset_i = 1'b1;
    #1;
    chk("async_rst_trig", 64'(O_trigger), 64'd0);
    chk("async_rst_busy", 64'(O_busy), 64'd0);
    #2 reset_i = 1'b0;
    tick();
    run_trace(12, -1, -1);
    chk("post_rst_trig", tr_trig, 64'h0);
    chk("post_rst_done", tr_done, 64'h0);

    // Width 0 behaves as width 1
    cfg(1); set_pulse(0, 2, 0);
    do_match();
    run_trace(10, -1, -1);
    chk("w0_trig", tr_trig, 64'h8);
    chk("w0_done", tr_done, 64'h20);

    // Maximum delay rises 2^DW cycles after the match edge
    cfg(1); set_pulse(0, (1 << DW) - 1, 1);
    do_match();
    n = 0;
    while (O_trigger !== 1'b1 && n < 5000) begin
      tick();
      n++;
    end
    chk("max_delay_rise", 64'(n), 64'd4096);
    n = 0;
    while (O_done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("max_delay_done", 64'(n), 64'd2);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
